// File: rtl/id_ex_stage.sv
// Register-read / issue stage: captures operands (with same-cycle writeback bypass)
// into a two-entry skid buffer and keeps held operands coherent by snooping writebacks.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic              i_Flush,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [XLEN-1:0]   i_PC,
  input  logic [XLEN-1:0]   i_Imm,
  input  logic [4:0]        i_Rs1,
  input  logic [4:0]        i_Rs2,
  input  logic [4:0]        i_Rd,
  input  logic [CTRL_W-1:0] i_Ctrl,
  output logic [4:0]        o_A1,
  output logic [4:0]        o_A2,
  input  logic [XLEN-1:0]   i_RD1,
  input  logic [XLEN-1:0]   i_RD2,
  input  logic [4:0]        i_WB_A3,
  input  logic              i_WB_WE3,
  input  logic [XLEN-1:0]   i_WB_WD3,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [XLEN-1:0]   o_PC,
  output logic [XLEN-1:0]   o_Imm,
  output logic [XLEN-1:0]   o_Op1,
  output logic [XLEN-1:0]   o_Op2,
  output logic [4:0]        o_Rs1,
  output logic [4:0]        o_Rs2,
  output logic [4:0]        o_Rd,
  output logic [CTRL_W-1:0] o_Ctrl
);

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // Upstream ready depends only on skid occupancy, never on downstream ready.
  logic              r_m_valid, r_s_valid;
  logic [XLEN-1:0]   r_m_pc, r_m_imm, r_m_op1, r_m_op2;
  logic [XLEN-1:0]   r_s_pc, r_s_imm, r_s_op1, r_s_op2;
  logic [4:0]        r_m_rs1, r_m_rs2, r_m_rd;
  logic [4:0]        r_s_rs1, r_s_rs2, r_s_rd;
  logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;

  logic              w_accept, w_drain, w_wb_live;
  logic [XLEN-1:0]   w_in_op1, w_in_op2;
  logic [XLEN-1:0]   w_m_op1, w_m_op2, w_s_op1, w_s_op2;

  assign o_A1      = i_Rs1;
  assign o_A2      = i_Rs2;
  assign o_Ready   = ~r_s_valid;
  assign o_Valid   = r_m_valid;
  assign w_accept  = i_Valid & ~r_s_valid;
  assign w_drain   = r_m_valid & i_Ready;
  assign w_wb_live = i_WB_WE3 & (i_WB_A3 != 5'd0);

  // The regfile write lands on the same edge as this read, so bypass it here.
  assign w_in_op1 = (i_Rs1 == 5'd0) ? '0 :
                    (w_wb_live && i_WB_A3 == i_Rs1) ? i_WB_WD3 : i_RD1;
  assign w_in_op2 = (i_Rs2 == 5'd0) ? '0 :
                    (w_wb_live && i_WB_A3 == i_Rs2) ? i_WB_WD3 : i_RD2;

  // Snooped views of held operands; they feed both the in-place hold and S->M moves.
  assign w_m_op1 = (w_wb_live && i_WB_A3 == r_m_rs1) ? i_WB_WD3 : r_m_op1;
  assign w_m_op2 = (w_wb_live && i_WB_A3 == r_m_rs2) ? i_WB_WD3 : r_m_op2;
  assign w_s_op1 = (w_wb_live && i_WB_A3 == r_s_rs1) ? i_WB_WD3 : r_s_op1;
  assign w_s_op2 = (w_wb_live && i_WB_A3 == r_s_rs2) ? i_WB_WD3 : r_s_op2;

  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_pc    <= '0;
      r_m_imm   <= '0;
      r_m_op1   <= '0;
      r_m_op2   <= '0;
      r_m_rs1   <= '0;
      r_m_rs2   <= '0;
      r_m_rd    <= '0;
      r_m_ctrl  <= '0;
      r_s_pc    <= '0;
      r_s_imm   <= '0;
      r_s_op1   <= '0;
      r_s_op2   <= '0;
      r_s_rs1   <= '0;
      r_s_rs2   <= '0;
      r_s_rd    <= '0;
      r_s_ctrl  <= '0;
    end else begin
      r_m_op1 <= w_m_op1;
      r_m_op2 <= w_m_op2;
      r_s_op1 <= w_s_op1;
      r_s_op2 <= w_s_op2;
      if (i_Flush) begin
        r_m_valid <= 1'b0;
        r_s_valid <= 1'b0;
      end else if (!r_m_valid || w_drain) begin
        if (r_s_valid) begin
          r_m_valid <= 1'b1;
          r_m_pc    <= r_s_pc;
          r_m_imm   <= r_s_imm;
          r_m_op1   <= w_s_op1;
          r_m_op2   <= w_s_op2;
          r_m_rs1   <= r_s_rs1;
          r_m_rs2   <= r_s_rs2;
          r_m_rd    <= r_s_rd;
          r_m_ctrl  <= r_s_ctrl;
          r_s_valid <= w_accept;
          if (w_accept) begin
            r_s_pc   <= i_PC;
            r_s_imm  <= i_Imm;
            r_s_op1  <= w_in_op1;
            r_s_op2  <= w_in_op2;
            r_s_rs1  <= i_Rs1;
            r_s_rs2  <= i_Rs2;
            r_s_rd   <= i_Rd;
            r_s_ctrl <= i_Ctrl;
          end
        end else if (w_accept) begin
          r_m_valid <= 1'b1;
          r_m_pc    <= i_PC;
          r_m_imm   <= i_Imm;
          r_m_op1   <= w_in_op1;
          r_m_op2   <= w_in_op2;
          r_m_rs1   <= i_Rs1;
          r_m_rs2   <= i_Rs2;
          r_m_rd    <= i_Rd;
          r_m_ctrl  <= i_Ctrl;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_s_valid <= 1'b1;
        r_s_pc    <= i_PC;
        r_s_imm   <= i_Imm;
        r_s_op1   <= w_in_op1;
        r_s_op2   <= w_in_op2;
        r_s_rs1   <= i_Rs1;
        r_s_rs2   <= i_Rs2;
        r_s_rd    <= i_Rd;
        r_s_ctrl  <= i_Ctrl;
      end
    end
  end

  assign o_PC   = r_m_pc;
  assign o_Imm  = r_m_imm;
  assign o_Op1  = r_m_op1;
  assign o_Op2  = r_m_op2;
  assign o_Rs1  = r_m_rs1;
  assign o_Rs2  = r_m_rs2;
  assign o_Rd   = r_m_rd;
  assign o_Ctrl = r_m_ctrl;

endmodule
